// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state encoding and per-transfer configuration.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PA,
        PB,
        HOLD
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
        logic keep_ss;
    } spi_cfg_t;

endpackage

// File: rtl/spi_halfper_tick.sv
// Half-period counter: counts 0..limit while enabled and flags the last cycle of each phase.
module spi_halfper_tick #(
    parameter int DVSR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [DVSR_W-1:0] limit,
    output logic              tick
);

    logic [DVSR_W-1:0] cnt;

    assign tick = en && (cnt == limit);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_core.sv
// SPI master: one DATA_W-bit word per transfer, runtime SCLK divisor, all four modes,
// MSB/LSB-first order and active-low slave selects with optional hold across words.
module spi_master_core
    import spi_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_SS   = 1,
    parameter int DVSR_W   = 16,
    parameter int SS_IDX_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   din,
    input  logic [DVSR_W-1:0]   dvsr,
    input  logic                cpol,
    input  logic                cpha,
    input  logic                lsb_first,
    input  logic [SS_IDX_W-1:0] ss_sel,
    input  logic                keep_ss,
    input  logic                start,
    output logic                ready,
    output logic                done_tick,
    output logic [DATA_W-1:0]   dout,
    output logic                sclk,
    output logic                mosi,
    input  logic                miso,
    output logic [NUM_SS-1:0]   ss_n
);

    localparam int BIT_W = $clog2(DATA_W);

    spi_state_e        state;
    spi_cfg_t          cfg;
    logic [DVSR_W-1:0] dvsr_q;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [BIT_W-1:0]  bit_cnt;
    logic              tick;

    assign ready = (state == IDLE);

    spi_halfper_tick #(
        .DVSR_W(DVSR_W)
    ) u_halfper (
        .clk  (clk),
        .rst  (rst),
        .clear(state == IDLE),
        .en   (state != IDLE),
        .limit(dvsr_q),
        .tick (tick)
    );

    // An out-of-range index matches no bit, so every select stays deasserted.
    function automatic logic [NUM_SS-1:0] sel_mask(input logic [SS_IDX_W-1:0] idx);
        logic [NUM_SS-1:0] m;
        m = '1;
        for (int unsigned i = 0; i < NUM_SS; i++) begin
            if (idx == SS_IDX_W'(i)) m[i] = 1'b0;
        end
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cfg       <= '0;
            dvsr_q    <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            bit_cnt   <= '0;
            dout      <= '0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            ss_n      <= '1;
            done_tick <= 1'b0;
        end else begin
            done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg     <= {cpol, cpha, lsb_first, keep_ss};
                        dvsr_q  <= dvsr;
                        tx_sh   <= din;
                        bit_cnt <= '0;
                        ss_n    <= sel_mask(ss_sel);
                        sclk    <= cpol;
                        mosi    <= lsb_first ? din[0] : din[DATA_W-1];
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        sclk  <= cfg.cpol ^ cfg.cpha;
                        state <= PA;
                    end
                end
                PA: begin
                    if (tick) begin
                        sclk  <= cfg.cpol ^ ~cfg.cpha;
                        rx_sh <= cfg.lsb_first ? {miso, rx_sh[DATA_W-1:1]}
                                               : {rx_sh[DATA_W-2:0], miso};
                        state <= PB;
                    end
                end
                PB: begin
                    if (tick) begin
                        if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                            sclk  <= cfg.cpol;
                            state <= HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            sclk    <= cfg.cpol ^ cfg.cpha;
                            if (cfg.lsb_first) begin
                                tx_sh <= {1'b0, tx_sh[DATA_W-1:1]};
                                mosi  <= tx_sh[1];
                            end else begin
                                tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                                mosi  <= tx_sh[DATA_W-2];
                            end
                            state <= PA;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        dout      <= rx_sh;
                        done_tick <= 1'b1;
                        if (!cfg.keep_ss) ss_n <= '1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: an 8-bit single-select instance and a 16-bit four-select instance.
module tb_spi_master_core;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0]  din8     = '0;
    logic [15:0] dvsr8    = '0;
    logic        cpol8    = 1'b0;
    logic        cpha8    = 1'b0;
    logic        lsb8     = 1'b0;
    logic [0:0]  ss_sel8  = '0;
    logic        keep8    = 1'b0;
    logic        start8   = 1'b0;
    logic        loop8    = 1'b1;
    logic        miso_drv8 = 1'b0;
    logic        ready8, done8, sclk8, mosi8, miso8;
    logic [7:0]  dout8;
    logic [0:0]  ss_n8;

    logic [15:0] din16    = '0;
    logic [15:0] dvsr16   = '0;
    logic [1:0]  ss_sel16 = 2'd2;
    logic        keep16   = 1'b0;
    logic        start16  = 1'b0;
    logic        ready16, done16, sclk16, mosi16;
    logic [15:0] dout16;
    logic [3:0]  ss_n16;

    int checks   = 0;
    int failures = 0;

    assign miso8 = loop8 ? mosi8 : miso_drv8;

    always #5 clk = ~clk;

    spi_master_core u_dut8 (
        .clk(clk), .rst(rst), .din(din8), .dvsr(dvsr8), .cpol(cpol8), .cpha(cpha8),
        .lsb_first(lsb8), .ss_sel(ss_sel8), .keep_ss(keep8), .start(start8),
        .ready(ready8), .done_tick(done8), .dout(dout8), .sclk(sclk8), .mosi(mosi8),
        .miso(miso8), .ss_n(ss_n8)
    );

    spi_master_core #(
        .DATA_W(16),
        .NUM_SS(4)
    ) u_dut16 (
        .clk(clk), .rst(rst), .din(din16), .dvsr(dvsr16), .cpol(1'b0), .cpha(1'b0),
        .lsb_first(1'b0), .ss_sel(ss_sel16), .keep_ss(keep16), .start(start16),
        .ready(ready16), .done_tick(done16), .dout(dout16), .sclk(sclk16), .mosi(mosi16),
        .miso(mosi16), .ss_n(ss_n16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (ready8 !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready8); end
        checks++; if (sclk8 !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk8); end
        checks++; if (mosi8 !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", mosi8); end
        checks++; if (ss_n8 !== 1'b1) begin failures++; $display("FAIL reset_ss_n got=%b exp=1", ss_n8); end
        checks++; if (dout8 !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout8); end
        checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done8); end
        checks++; if (ss_n16 !== 4'hF) begin failures++; $display("FAIL reset_ss_n16 got=%b exp=1111", ss_n16); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_mode0();
        int n, rises;
        logic prev, ss_ok;
        loop8 = 1'b1; din8 = 8'hA5; dvsr8 = 16'd1; cpol8 = 1'b0; cpha8 = 1'b0;
        lsb8 = 1'b0; ss_sel8 = 1'b0; keep8 = 1'b0;
        prev = sclk8;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        n = 1; rises = 0; ss_ok = 1'b1;
        while (!done8 && n < 100) begin
            if (sclk8 && !prev) rises++;
            prev = sclk8;
            if (ss_n8 !== 1'b0) ss_ok = 1'b0;
            step();
            n++;
        end
        checks++; if (n != 37) begin failures++; $display("FAIL m0_latency got=%0d exp=37", n); end
        checks++; if (dout8 !== 8'hA5) begin failures++; $display("FAIL m0_dout got=%h exp=a5", dout8); end
        checks++; if (rises != 8) begin failures++; $display("FAIL m0_rises got=%0d exp=8", rises); end
        checks++; if (ss_ok !== 1'b1) begin failures++; $display("FAIL m0_ss_low got=%b exp=1", ss_ok); end
        checks++; if (ss_n8 !== 1'b1) begin failures++; $display("FAIL m0_ss_release got=%b exp=1", ss_n8); end
        checks++; if (sclk8 !== 1'b0) begin failures++; $display("FAIL m0_sclk_idle got=%b exp=0", sclk8); end
    endtask

    task automatic test_mode3_lsb();
        int n, idx;
        logic prev;
        logic [7:0] pat, seq;
        loop8 = 1'b0; miso_drv8 = 1'b0; din8 = 8'h3C; dvsr8 = 16'd0;
        cpol8 = 1'b1; cpha8 = 1'b1; lsb8 = 1'b1; keep8 = 1'b0;
        pat = 8'h81; seq = '0; idx = 0;
        prev = sclk8;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 100) begin
            // slave side of mode 3: present the next bit on each falling edge
            if (prev && !sclk8 && idx < 8) begin
                miso_drv8 = pat[idx];
                seq = {seq[6:0], mosi8};
                idx++;
            end
            prev = sclk8;
            step();
            n++;
        end
        checks++; if (n != 19) begin failures++; $display("FAIL m3_latency got=%0d exp=19", n); end
        checks++; if (dout8 !== 8'h81) begin failures++; $display("FAIL m3_dout got=%h exp=81", dout8); end
        checks++; if (seq !== 8'b00111100) begin failures++; $display("FAIL m3_mosi_order got=%b exp=00111100", seq); end
        checks++; if (idx != 8) begin failures++; $display("FAIL m3_edges got=%0d exp=8", idx); end
        checks++; if (sclk8 !== 1'b1) begin failures++; $display("FAIL m3_sclk_idle got=%b exp=1", sclk8); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        logic        keeps [3];
        int n, ss_bad;
        words = '{16'h1234, 16'hBEEF, 16'h5A5A};
        keeps = '{1'b1, 1'b1, 1'b0};
        dvsr16 = 16'd0; ss_sel16 = 2'd2;
        for (int w = 0; w < 3; w++) begin
            if (w > 0) begin
                checks++; if (done16 !== 1'b1 || ready16 !== 1'b1) begin
                    failures++; $display("FAIL b2b_done_ready_%0d got=%b%b exp=11", w, done16, ready16);
                end
            end
            din16 = words[w]; keep16 = keeps[w];
            start16 = 1'b1;
            step();
            start16 = 1'b0;
            n = 1; ss_bad = 0;
            while (!done16 && n < 100) begin
                if (ss_n16 !== 4'b1011) ss_bad++;
                step();
                n++;
            end
            checks++; if (n != 35) begin failures++; $display("FAIL b2b_latency_%0d got=%0d exp=35", w, n); end
            checks++; if (dout16 !== words[w]) begin failures++; $display("FAIL b2b_dout_%0d got=%h exp=%h", w, dout16, words[w]); end
            checks++; if (ss_bad != 0) begin failures++; $display("FAIL b2b_ss_busy_%0d got=%0d exp=0", w, ss_bad); end
            checks++; if (ss_n16 !== (keeps[w] ? 4'b1011 : 4'b1111)) begin
                failures++; $display("FAIL b2b_ss_done_%0d got=%b exp=%b", w, ss_n16, keeps[w] ? 4'b1011 : 4'b1111);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int n, extra;
        loop8 = 1'b1; din8 = 8'h3C; dvsr8 = 16'd2; cpol8 = 1'b0; cpha8 = 1'b0;
        lsb8 = 1'b0; ss_sel8 = 1'b0; keep8 = 1'b0;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 200) begin
            if (n == 10) begin
                start8 = 1'b1; din8 = 8'hFF; dvsr8 = 16'd0;
                cpol8 = 1'b1; cpha8 = 1'b1; lsb8 = 1'b1; ss_sel8 = 1'b1;
            end
            if (n == 14) start8 = 1'b0;
            step();
            n++;
        end
        checks++; if (n != 55) begin failures++; $display("FAIL ign_latency got=%0d exp=55", n); end
        checks++; if (dout8 !== 8'h3C) begin failures++; $display("FAIL ign_dout got=%h exp=3c", dout8); end
        checks++; if (sclk8 !== 1'b0) begin failures++; $display("FAIL ign_sclk_idle got=%b exp=0", sclk8); end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done8) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL ign_extra_done got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid();
        int n;
        loop8 = 1'b1; din8 = 8'h96; dvsr8 = 16'd1; cpol8 = 1'b0; cpha8 = 1'b0;
        lsb8 = 1'b0; ss_sel8 = 1'b0; keep8 = 1'b0;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (n = 1; n < 21; n++) step();
        checks++; if (sclk8 !== 1'b1 || ss_n8 !== 1'b0) begin
            failures++; $display("FAIL rstmid_in_pb got=%b%b exp=10", sclk8, ss_n8);
        end
        rst = 1'b1;
        step();
        checks++; if (sclk8 !== 1'b0) begin failures++; $display("FAIL rstmid_sclk got=%b exp=0", sclk8); end
        checks++; if (ss_n8 !== 1'b1) begin failures++; $display("FAIL rstmid_ss_n got=%b exp=1", ss_n8); end
        checks++; if (ready8 !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", ready8); end
        checks++; if (dout8 !== 8'h00) begin failures++; $display("FAIL rstmid_dout got=%h exp=00", dout8); end
        checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done8); end
        rst = 1'b0;
        step();
        din8 = 8'h69;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 100) begin
            step();
            n++;
        end
        checks++; if (n != 37) begin failures++; $display("FAIL rstmid_re_latency got=%0d exp=37", n); end
        checks++; if (dout8 !== 8'h69) begin failures++; $display("FAIL rstmid_re_dout got=%h exp=69", dout8); end
    endtask

    task automatic test_cpha();
        int n, nsamp, bad_mosi;
        logic prev_s, prev_m, last_miso, pa_lvl;
        logic [7:0] rx_ref, tx_seen;
        for (int c = 0; c < 2; c++) begin
            loop8 = 1'b0; din8 = 8'hC9; dvsr8 = 16'd3; cpol8 = 1'b0;
            cpha8 = c[0]; lsb8 = 1'b0; keep8 = 1'b0;
            pa_lvl = c[0];
            prev_s = sclk8; prev_m = mosi8;
            last_miso = 1'b0; miso_drv8 = 1'b0;
            rx_ref = '0; tx_seen = '0; nsamp = 0; bad_mosi = 0;
            start8 = 1'b1;
            step();
            start8 = 1'b0;
            n = 1;
            while (!done8 && n < 200) begin
                // mosi may only move when sclk has just entered the PA level from PB
                if (n > 1 && mosi8 !== prev_m && !(prev_s !== sclk8 && sclk8 === pa_lvl)) bad_mosi++;
                if (prev_s === pa_lvl && sclk8 !== pa_lvl) begin
                    rx_ref  = {rx_ref[6:0], last_miso};
                    tx_seen = {tx_seen[6:0], prev_m};
                    nsamp++;
                end
                prev_s = sclk8; prev_m = mosi8;
                last_miso = 1'($urandom_range(0, 1));
                miso_drv8 = last_miso;
                step();
                n++;
            end
            checks++; if (n != 73) begin failures++; $display("FAIL cpha%0d_latency got=%0d exp=73", c, n); end
            checks++; if (nsamp != 8) begin failures++; $display("FAIL cpha%0d_samples got=%0d exp=8", c, nsamp); end
            checks++; if (dout8 !== rx_ref) begin failures++; $display("FAIL cpha%0d_dout got=%h exp=%h", c, dout8, rx_ref); end
            checks++; if (tx_seen !== 8'hC9) begin failures++; $display("FAIL cpha%0d_mosi got=%h exp=c9", c, tx_seen); end
            checks++; if (bad_mosi != 0) begin failures++; $display("FAIL cpha%0d_mosi_edges got=%0d exp=0", c, bad_mosi); end
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3_lsb();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_cpha();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_master_core.md
Name: spi_master_core

Overview:
- Parametrised SPI master that serialises one DATA_W-bit word per transaction over MOSI and captures MISO into dout.
- SCLK frequency is set at runtime by dvsr.
- All four SPI modes are supported, selected per transaction via cpol/cpha; MSB- or LSB-first order is selectable.
- Drives NUM_SS active-low slave selects with optional select hold across words. Sits behind the MMIO SPI register wrapper.

Parameters:
- DATA_W, 8, bits per transfer word (>=2).
- NUM_SS, 1, number of slave-select outputs (>=1).
- DVSR_W, 16, width of the half-period divisor.
- SS_IDX_W, (NUM_SS>1 ? $clog2(NUM_SS) : 1), width of ss_sel.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- din  in  DATA_W  word to transmit, sampled on accepted start
- dvsr  in  DVSR_W  half-period = dvsr+1 clk cycles, sampled on accepted start
- cpol  in  1  SCLK idle level, sampled on accepted start
- cpha  in  1  clock phase, sampled on accepted start
- lsb_first  in  1  1 = LSB shifted first, sampled on accepted start
- ss_sel  in  SS_IDX_W  slave index, sampled on accepted start
- keep_ss  in  1  1 = leave slave selected after done, sampled on accepted start
- start  in  1  request transfer; accepted only when ready=1
- ready  out  1  high in IDLE
- done_tick  out  1  one-cycle pulse, transfer complete
- dout  out  DATA_W  received word, stable from done_tick until next accepted start
- sclk  out  1  SPI clock, registered
- mosi  out  1  serial data out, registered
- miso  in  1  serial data in
- ss_n  out  NUM_SS  active-low selects, registered

Behaviour:
- Reset (rst=1 at a posedge, including mid-transfer): state=IDLE; sclk=0; mosi=0; ss_n=all 1; dout=0; done_tick=0; ready=1 the following cycle; counters=0. Latched cpol resets to 0.
- Half-period counter: counts 0..dvsr_q; a phase ends in the cycle where cnt==dvsr_q, then cnt returns to 0. dvsr=0 gives a 1-cycle half-period.
- States: IDLE, SETUP, PA, PB, HOLD.
- IDLE: ready=1. On start, latch din into tx_sh and latch all config inputs; go to SETUP.
- Select on start: ss_n[ss_sel]=0 from the next cycle and all other bits 1. This also replaces any held select. ss_sel >= NUM_SS selects no slave; the transfer still runs.
- SETUP: one half-period. sclk=cpol. mosi=first bit: tx_sh[DATA_W-1], or tx_sh[0] if lsb_first. Next state: PA.
- PA then PB: each one half-period, repeated DATA_W times.
- SCLK value: sclk = cpol ^ (cpha ? (state==PA) : (state==PB)).
- Sample: miso is sampled into rx_sh at the PA->PB transition. MSB-first shifts in at the LSB end; LSB-first shifts in at the MSB end. After DATA_W samples, the first received bit is at the same end it was transmitted from.
- Shift: at each PB->PA transition, tx_sh shifts and mosi presents the next bit. mosi never changes at the PA->PB sample edge.
- Bit count: bit counter 0..DATA_W-1. At PB end with bit==DATA_W-1, go to HOLD.
- HOLD: one half-period. sclk=cpol. mosi holds the last bit. ss_n is still asserted.
- HOLD end: state=IDLE and dout<=rx_sh. done_tick=1 in the first IDLE cycle.
- Select after done: if keep_ss_q=1, ss_n stays asserted; otherwise ss_n returns to all 1 in that same cycle.
- Latency: start accepted at cycle 0 gives done_tick at cycle 1+(2*DATA_W+2)*(dvsr+1).
- Back-to-back: start in the done_tick cycle is accepted.
- Ignored inputs: start while ready=0 is ignored. din and config changes mid-transfer have no effect.
- mosi in IDLE holds its last value (0 after reset).

Decomposition:
- Package spi_pkg: state enum spi_state_e {IDLE, SETUP, PA, PB, HOLD}; packed struct spi_cfg_t {cpol, cpha, lsb_first, keep_ss}.
- Sub-module spi_halfper_tick: loadable DVSR_W counter with clear and a phase-end tick output. Instantiated once.
- The FSM and shift registers live in spi_master_core.

Test Plan:
- Mode 0, MSB-first, DATA_W=8, dvsr=1, miso looped to mosi, din=0xA5 -> dout=0xA5. done_tick at cycle 37. sclk shows 8 rising edges, idling at 0. ss_n[0] is low from cycle 1 to 36.
- Mode 3, lsb_first=1, dvsr=0, din=0x3C, miso driven with the bit pattern of 0x81 LSB-first on the sample edges -> dout=0x81. sclk idles at 1. mosi order is 0,0,1,1,1,1,0,0. done_tick at cycle 19.
- DATA_W=16, NUM_SS=4, ss_sel=2, keep_ss=1, two back-to-back words 0x1234 and 0xBEEF -> ss_n=4'b1011 continuously across both words. Second start is accepted in the first done_tick cycle. A third word with keep_ss=0 releases ss_n to 4'b1111 at its done_tick.
- Start pulses while busy and din/dvsr changed mid-transfer -> no effect. Exactly one done_tick. Timing follows the original dvsr.
- rst=1 asserted during PB of bit 4 -> next cycle sclk=0, ss_n=all 1, ready=1, dout=0, no done_tick. A new transfer then completes correctly.
- cpha=1 vs cpha=0 with dvsr=3 -> mosi transitions occur only at PB->PA boundaries. miso is sampled exactly once per bit at the PA->PB boundary; the checker compares against a reference model.
